// File: rtl/rom_boot_loader.sv
// Boot-data consumer: takes 32-bit words over a four-phase req/ack handshake
// and writes them MSB-first, one byte at a time, into the SRAM ROM area.
module rom_boot_loader #(
  parameter int                    ADDR_WIDTH  = 19,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    TOTAL_BYTES = 49152,
  parameter int                    WR_PULSE    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  host_reset,
  input  logic [31:0]           host_bootdata,
  input  logic                  host_bootdata_req,
  output logic                  host_bootdata_ack,
  output logic [ADDR_WIDTH-1:0] romwrite_addr,
  output logic [7:0]            romwrite_data,
  output logic                  romwrite_wr,
  output logic                  rom_initialised
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int PW = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
  localparam logic [CW-1:0] TOTAL      = CW'(TOTAL_BYTES);
  localparam logic [PW-1:0] PULSE_LAST = PW'(WR_PULSE - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_RELEASE, ST_DONE
  } state_t;

  state_t          state_reg;
  logic [31:0]     word_reg;
  logic [1:0]      idx_reg;
  logic [CW-1:0]   count_reg;
  logic [PW-1:0]   pulse_reg;

  logic [7:0]            word_bytes [4];
  logic [CW-1:0]         count_inc;
  logic [1:0]            idx_inc;
  logic [ADDR_WIDTH-1:0] addr_cur;
  logic [ADDR_WIDTH-1:0] addr_inc;

  // Byte 0 is the most significant byte of the latched word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
      assign word_bytes[gi] = word_reg[31-8*gi -: 8];
    end
  endgenerate

  assign count_inc = count_reg + 1'b1;
  assign idx_inc   = idx_reg + 2'd1;
  // The address wraps modulo 2^ADDR_WIDTH; the counter's top bit only feeds the length compare.
  assign addr_cur  = BASE_ADDR + count_reg[ADDR_WIDTH-1:0];
  assign addr_inc  = BASE_ADDR + count_inc[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= ST_IDLE;
      word_reg          <= '0;
      idx_reg           <= '0;
      count_reg         <= '0;
      pulse_reg         <= '0;
      host_bootdata_ack <= 1'b0;
      romwrite_addr     <= BASE_ADDR;
      romwrite_data     <= '0;
      romwrite_wr       <= 1'b0;
      rom_initialised   <= 1'b0;
    end else if (host_reset) begin
      // An in-flight byte is abandoned, not completed.
      state_reg         <= ST_IDLE;
      count_reg         <= '0;
      pulse_reg         <= '0;
      host_bootdata_ack <= 1'b0;
      romwrite_wr       <= 1'b0;
      rom_initialised   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (host_bootdata_req && !host_bootdata_ack) begin
            word_reg          <= host_bootdata;
            idx_reg           <= 2'd0;
            host_bootdata_ack <= 1'b1;
            romwrite_addr     <= addr_cur;
            romwrite_data     <= host_bootdata[31:24];
            state_reg         <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          romwrite_wr <= 1'b1;
          pulse_reg   <= '0;
          state_reg   <= ST_PULSE;
        end
        ST_PULSE: begin
          if (pulse_reg == PULSE_LAST) begin
            romwrite_wr <= 1'b0;
            state_reg   <= ST_HOLD;
          end else begin
            pulse_reg <= pulse_reg + 1'b1;
          end
        end
        ST_HOLD: begin
          count_reg <= count_inc;
          if (count_inc == TOTAL) begin
            // Remaining bytes of a partial final word are dropped here.
            rom_initialised <= 1'b1;
            state_reg       <= ST_RELEASE;
          end else if (idx_reg != 2'd3) begin
            idx_reg       <= idx_inc;
            romwrite_addr <= addr_inc;
            romwrite_data <= word_bytes[idx_inc];
            state_reg     <= ST_SETUP;
          end else begin
            state_reg <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!host_bootdata_req) begin
            host_bootdata_ack <= 1'b0;
            state_reg         <= rom_initialised ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: begin
          host_bootdata_ack <= 1'b0;
          romwrite_wr       <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rom_boot_loader.md
# rom_boot_loader

Consumer end of the host boot-data channel: accepts 32-bit words from the control module over a four-phase req/ack handshake, unpacks each word into four bytes (MSB first) and writes them sequentially into the ROM area of the machine's SRAM. Sits inside the CPC core between the host interface (`host_bootdata*`) and the SRAM arbiter. It raises `rom_initialised` once the configured image length has been written; the arbiter then hands the SRAM back to the CPU.

## Interface
Parameters:
- `ADDR_WIDTH`, 19, width of `romwrite_addr`.
- `BASE_ADDR`, 19'h00000, SRAM address of the first ROM byte.
- `TOTAL_BYTES`, 49152, image length in bytes (OS + BASIC + AMSDOS, 3 × 16 KB); any value 1..2^ADDR_WIDTH is legal.
- `WR_PULSE`, 1, cycles `romwrite_wr` is held high per byte (≥1).

Ports:
- `clk`  in  1  system clock; same domain as the host interface.
- `reset_n`  in  1  asynchronous, active-low reset.
- `host_reset`  in  1  synchronous restart; clears progress and restarts loading.
- `host_bootdata`  in  32  data word; stable while `host_bootdata_req` is high.
- `host_bootdata_req`  in  1  host request; level signal.
- `host_bootdata_ack`  out  1  loader acknowledge.
- `romwrite_addr`  out  ADDR_WIDTH  SRAM byte address.
- `romwrite_data`  out  8  SRAM write data.
- `romwrite_wr`  out  1  SRAM write strobe, active high.
- `rom_initialised`  out  1  image complete; sticky until reset or `host_reset`.

## Operation
- Reset values: ack=0, wr=0, addr=BASE_ADDR, data=0, rom_initialised=0, byte counter=0, state IDLE.
- States: IDLE, SETUP, PULSE, HOLD, RELEASE, DONE.
- IDLE: on req=1 && ack=0, latch `host_bootdata` into a word register, set ack=1, set byte index=0, go to SETUP.
- SETUP: drive addr=BASE_ADDR+counter and data=word[31:24] for index 0, [23:16] for 1, [15:8] for 2, [7:0] for 3. wr stays 0. Go to PULSE.
- PULSE: wr=1 for WR_PULSE cycles; addr and data held. Go to HOLD.
- HOLD: wr=0; addr and data held; counter+1. If counter+1 == TOTAL_BYTES, set rom_initialised=1 and go to RELEASE. Otherwise, if index<3, index+1 and go to SETUP; else go to RELEASE.
- RELEASE: hold ack=1 until req=0 is sampled, then ack=0. Go to DONE if rom_initialised is set, else IDLE.
- DONE: ack stays 0 and wr stays 0. Further requests are ignored; ack never rises.
- Counter is ADDR_WIDTH+1 bits. The address is (BASE_ADDR + counter) truncated to ADDR_WIDTH, so it wraps modulo 2^ADDR_WIDTH.
- Partial final word: bytes beyond TOTAL_BYTES are discarded and not written.
- `host_reset` (any state, priority over all else): next cycle wr=0, ack=0, counter=0, rom_initialised=0, state IDLE. An aborted byte is not completed. If req is still high, a new word is accepted on the following IDLE cycle.
- Host protocol violation: if req drops before the loader's writes finish, the latched word is still written in full. ack falls only from RELEASE.

## Timing
- req sampled high at edge N in IDLE → ack=1 after edge N. The first SETUP address and data are visible in the same cycle.
- Per byte: 2+WR_PULSE cycles (SETUP, PULSE×WR_PULSE, HOLD). The default is 3 cycles per byte, 12 per word.
- ack falls one cycle after req=0 is sampled in RELEASE. Minimum word period: 1 (IDLE) + 4×(2+WR_PULSE) + 1 cycles.
- addr and data are stable from SETUP through HOLD, giving one cycle of setup and one of hold around wr.
- rom_initialised rises on the edge that ends the HOLD of byte TOTAL_BYTES−1, before the final ack falls.

## Test plan
- Single word: TOTAL_BYTES=8, word 0x11223344 with req held until ack → writes (0x00000,0x11), (1,0x22), (2,0x33), (3,0x44). Each wr pulse is 1 cycle; ack rises 1 cycle after req and falls 1 cycle after req drops; rom_initialised stays 0.
- Full image: TOTAL_BYTES=8, two words 0xA1A2A3A4, 0xB1B2B3B4 → 8 writes at addr 0..7. rom_initialised=1 after the 8th HOLD. A third req stays unacknowledged for 100 cycles with no wr.
- Partial last word: TOTAL_BYTES=6, words 0x01020304, 0x05060708 → exactly 6 writes, the last being (5,0x06). 0x07 and 0x08 are never written; ack completes normally.
- host_reset mid-word: assert during PULSE of byte 2 of word 0xDEADBEEF → wr=0 and ack=0 next cycle. The next word 0xCAFEF00D writes starting at addr BASE_ADDR with 0xCA.
- Slow host release: req held high 50 cycles after ack → ack stays 1 throughout and no second capture occurs. ack falls exactly 1 cycle after req falls.
- Async reset in RELEASE: reset_n low for 1 ns → all outputs at reset values immediately, without waiting for a clock edge.
